reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive blocked cycles before a stall request is raised.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: number of buffered MDU results.
REQ-003 SHALL have port CLK  in  1  clock; all state updates on posedge CLK.
REQ-004 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port PIPE_WRITE  in  1  pipeline writeback request, valid for one cycle.
REQ-006 SHALL have port PIPE_ADDR  in  5  pipeline destination register.
REQ-007 SHALL have port PIPE_DATA  in  32  pipeline result.
REQ-008 SHALL have port MDU_VALID  in  1  MUL/DIV unit result valid.
REQ-009 SHALL have port MDU_ADDR  in  5  MDU destination register.
REQ-010 SHALL have port MDU_DATA  in  32  MDU result.
REQ-011 SHALL have port MDU_READY  out  1  arbiter can accept an MDU result this cycle.
REQ-012 SHALL have port RF_WRITE  out  1  register-file write enable, registered.
REQ-013 SHALL have port RF_ADDR  out  5  register-file write address, registered.
REQ-014 SHALL have port RF_DATA  out  32  register-file write data, registered.
REQ-015 SHALL have port STALL_REQ  out  1  request that the pipeline withhold writebacks, registered.
REQ-016 SHALL have port PENDING  out  2  number of buffered MDU results, registered.

Function
REQ-017 SHALL accept an MDU transfer in any cycle where MDU_VALID=1 and MDU_READY=1.
REQ-018 SHALL drive MDU_READY = !RESET && (PENDING < FIFO_DEPTH), based on the registered count only; a same-cycle pop SHALL NOT raise READY.
REQ-019 SHALL drop an accepted MDU transfer with MDU_ADDR=0 without storing it and without changing PENDING.
REQ-020 SHALL treat PIPE_WRITE=1 with PIPE_ADDR=0 as no request; it SHALL NOT block the MDU path.
REQ-021 SHALL give priority to the pipeline: a valid pipeline request (PIPE_WRITE=1, PIPE_ADDR!=0) always produces RF_WRITE=1, RF_ADDR=PIPE_ADDR, RF_DATA=PIPE_DATA on the next cycle.
REQ-022 SHALL, when there is no valid pipeline request and the FIFO is non-empty, pop the FIFO head and present it on RF_* on the next cycle.
REQ-023 SHALL, when there is no valid pipeline request, the FIFO is empty and an MDU transfer with nonzero address is accepted, bypass the FIFO and present the transfer on RF_* on the next cycle, leaving PENDING unchanged.
REQ-024 SHALL otherwise enqueue an accepted nonzero MDU transfer at the FIFO tail.
REQ-025 SHALL support push and pop in the same cycle, with PENDING unchanged.
REQ-026 SHALL preserve FIFO order; MDU results SHALL never be reordered among themselves.
REQ-027 SHALL drive RF_WRITE=0 in any cycle following one with no pipeline write, no pop and no bypass; RF_ADDR and RF_DATA SHALL then hold their previous values.
REQ-028 SHALL keep a starvation counter: increment when the FIFO is non-empty and a valid pipeline request wins; clear on any pop or when the FIFO is empty; saturate at STARVE_LIMIT.
REQ-029 SHALL assert STALL_REQ on the cycle after the counter reaches STARVE_LIMIT, and deassert it on the cycle after the FIFO becomes empty.
REQ-030 SHALL still write a pipeline request that arrives while STALL_REQ=1; the pipeline honours the stall, the arbiter does not drop writes.
REQ-031 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH.

Reset
REQ-032 SHALL, when RESET=1 at posedge CLK, set RF_WRITE=0, RF_ADDR=0, RF_DATA=0, STALL_REQ=0, PENDING=0, empty the FIFO, clear the starvation counter and pointers.
REQ-033 SHALL hold MDU_READY=0 while RESET=1 and ignore all inputs; a reset arriving mid-operation SHALL discard buffered entries.

Verification
REQ-034 Idle, then MDU_VALID addr 5 data 0x1234 -> next cycle RF_WRITE=1, RF_ADDR=5, RF_DATA=0x1234, PENDING=0.
REQ-035 PIPE addr 3 data 0xA and MDU addr 7 data 0xB in the same cycle -> cycle+1 writes r3=0xA with PENDING=1; cycle+2 writes r7=0xB with PENDING=0.
REQ-036 Continuous PIPE writes, MDU pushes 0x1 then 0x2 -> PENDING=2 and MDU_READY=0; STALL_REQ=1 after 8 blocked cycles; PIPE idle -> r-writes 0x1 then 0x2, STALL_REQ=0 the cycle after empty.
REQ-037 PIPE addr 0 with MDU addr 9 data 0xC -> next cycle r9=0xC written; MDU addr 0 accepted -> no RF_WRITE and PENDING unchanged.
REQ-038 PENDING=2, RESET pulsed for one cycle -> all outputs 0, PENDING=0, MDU_READY=1 on the first cycle after reset, buffered data never written.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: merges single-cycle pipeline writebacks with
// buffered MUL/DIV results, pipeline first, and raises a stall when the MDU path starves.
module reg_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIPE_WRITE,
    input  logic [4:0]  PIPE_ADDR,
    input  logic [31:0] PIPE_DATA,
    input  logic        MDU_VALID,
    input  logic [4:0]  MDU_ADDR,
    input  logic [31:0] MDU_DATA,
    output logic        MDU_READY,
    output logic        RF_WRITE,
    output logic [4:0]  RF_ADDR,
    output logic [31:0] RF_DATA,
    output logic        STALL_REQ,
    output logic [1:0]  PENDING
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    wb_t           mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic          stall_q;
    logic          rf_write_q;
    wb_t           rf_q;

    logic          pipe_req;
    logic          mdu_rdy;
    logic          mdu_take;
    logic          fifo_empty;
    logic          pop;
    logic          bypass;
    logic          push;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic [SW-1:0] starve_nxt;
    logic          stall_nxt;
    logic          rf_write_nxt;
    wb_t           rf_nxt;
    wb_t           head;

    // Arbitration: valid pipeline write wins, then FIFO head, then MDU bypass.
    always_comb begin
        pipe_req     = PIPE_WRITE && (PIPE_ADDR != '0);
        mdu_rdy      = !RESET && (count < CW'(FIFO_DEPTH));
        mdu_take     = MDU_VALID && mdu_rdy && (MDU_ADDR != '0);
        fifo_empty   = (count == '0);
        pop          = !pipe_req && !fifo_empty;
        bypass       = !pipe_req && fifo_empty && mdu_take;
        push         = mdu_take && !bypass;
        head         = mem[rd_ptr];

        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        starve_nxt   = starve_cnt;
        stall_nxt    = stall_q;
        rf_write_nxt = 1'b0;
        rf_nxt       = rf_q;

        if (pipe_req) begin
            rf_write_nxt = 1'b1;
            rf_nxt       = '{addr: PIPE_ADDR, data: PIPE_DATA};
        end else if (pop) begin
            rf_write_nxt = 1'b1;
            rf_nxt       = head;
        end else if (bypass) begin
            rf_write_nxt = 1'b1;
            rf_nxt       = '{addr: MDU_ADDR, data: MDU_DATA};
        end

        if (push) begin
            wr_ptr_nxt = (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_nxt = (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end

        // Starvation: counts cycles the pipeline wins over a non-empty FIFO.
        if (fifo_empty || pop) begin
            starve_nxt = '0;
        end else if (pipe_req && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + SW'(1);
        end

        // Stall stays up while results drain, until the FIFO has been seen empty.
        if (fifo_empty) begin
            stall_nxt = 1'b0;
        end else if (starve_cnt == SW'(STARVE_LIMIT)) begin
            stall_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
            rf_write_q <= 1'b0;
            rf_q       <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            starve_cnt <= starve_nxt;
            stall_q    <= stall_nxt;
            rf_write_q <= rf_write_nxt;
            rf_q       <= rf_nxt;
        end
    end

    // Storage needs no reset; occupancy is tracked by count and pointers.
    always_ff @(posedge CLK) begin
        if (!RESET && push) begin
            mem[wr_ptr] <= '{addr: MDU_ADDR, data: MDU_DATA};
        end
    end

    assign MDU_READY = mdu_rdy;
    assign RF_WRITE  = rf_write_q;
    assign RF_ADDR   = rf_q.addr;
    assign RF_DATA   = rf_q.data;
    assign STALL_REQ = stall_q;
    assign PENDING   = 2'(count);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed vector table, starvation sequence,
// and random traffic checked against a queue-based scoreboard.
module tb_reg_wb_arbiter;

    logic        CLK;
    logic        RESET;
    logic        PIPE_WRITE;
    logic [4:0]  PIPE_ADDR;
    logic [31:0] PIPE_DATA;
    logic        MDU_VALID;
    logic [4:0]  MDU_ADDR;
    logic [31:0] MDU_DATA;
    logic        MDU_READY;
    logic        RF_WRITE;
    logic [4:0]  RF_ADDR;
    logic [31:0] RF_DATA;
    logic        STALL_REQ;
    logic [1:0]  PENDING;

    reg_wb_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .PIPE_WRITE(PIPE_WRITE), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA),
        .MDU_VALID(MDU_VALID), .MDU_ADDR(MDU_ADDR), .MDU_DATA(MDU_DATA),
        .MDU_READY(MDU_READY),
        .RF_WRITE(RF_WRITE), .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
        .STALL_REQ(STALL_REQ), .PENDING(PENDING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_rdy;
        logic        e_w;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [1:0]  e_p;
        logic        e_s;
    } vec_t;

    typedef struct packed {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs [18];
    exp_t sb [$];
    logic [36:0] mfifo [$];

    function automatic vec_t mk(int rst, int pw, int pa, int pd, int mv, int ma, int md,
                                int rdy, int w, int a, int d, int p, int s);
        vec_t v;
        v.rst = 1'(rst); v.pw = 1'(pw); v.pa = 5'(pa); v.pd = 32'(pd);
        v.mv = 1'(mv); v.ma = 5'(ma); v.md = 32'(md);
        v.e_rdy = 1'(rdy); v.e_w = 1'(w); v.e_a = 5'(a); v.e_d = 32'(d);
        v.e_p = 2'(p); v.e_s = 1'(s);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, outputs sampled 1 time unit after posedge.
    task automatic cyc(input logic rst, input logic pw, input logic [4:0] pa,
                       input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                       input logic [31:0] md);
        @(negedge CLK);
        RESET = rst; PIPE_WRITE = pw; PIPE_ADDR = pa; PIPE_DATA = pd;
        MDU_VALID = mv; MDU_ADDR = ma; MDU_DATA = md;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        exp_t        e;
        logic        preq;
        logic        take;
        logic        erdy;
        logic        pw;
        logic        mv;
        logic [4:0]  pa;
        logic [4:0]  ma;
        logic [31:0] pd;
        logic [31:0] md;
        logic [4:0]  last_a;
        logic [31:0] last_d;
        logic [36:0] ent;

        RESET = 1'b1; PIPE_WRITE = 1'b0; PIPE_ADDR = '0; PIPE_DATA = '0;
        MDU_VALID = 1'b0; MDU_ADDR = '0; MDU_DATA = '0;

        //        rst pw pa pd     mv ma md      rdy w  a  d       p  s
        vecs[0]  = mk(1, 0, 0, 0,     0, 0, 0,      0, 0, 0, 0,      0, 0);
        vecs[1]  = mk(0, 0, 0, 0,     0, 0, 0,      1, 0, 0, 0,      0, 0);
        vecs[2]  = mk(0, 0, 0, 0,     1, 5, 'h1234, 1, 1, 5, 'h1234, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,     0, 0, 0,      1, 0, 5, 'h1234, 0, 0);
        vecs[4]  = mk(0, 1, 3, 'hA,   1, 7, 'hB,    1, 1, 3, 'hA,    1, 0);
        vecs[5]  = mk(0, 0, 0, 0,     0, 0, 0,      1, 1, 7, 'hB,    0, 0);
        vecs[6]  = mk(0, 0, 0, 0,     0, 0, 0,      1, 0, 7, 'hB,    0, 0);
        vecs[7]  = mk(0, 1, 0, 'h55,  1, 9, 'hC,    1, 1, 9, 'hC,    0, 0);
        vecs[8]  = mk(0, 0, 0, 0,     1, 0, 'h77,   1, 0, 9, 'hC,    0, 0);
        vecs[9]  = mk(0, 1, 0, 'hFF,  0, 0, 0,      1, 0, 9, 'hC,    0, 0);
        vecs[10] = mk(0, 1, 1, 'h11,  1, 12, 'h100, 1, 1, 1, 'h11,   1, 0);
        vecs[11] = mk(0, 1, 2, 'h22,  1, 13, 'h200, 1, 1, 2, 'h22,   2, 0);
        vecs[12] = mk(1, 0, 0, 0,     1, 14, 'h300, 0, 0, 0, 0,      0, 0);
        vecs[13] = mk(0, 0, 0, 0,     0, 0, 0,      1, 0, 0, 0,      0, 0);
        vecs[14] = mk(0, 1, 4, 'h44,  1, 15, 'hF,   1, 1, 4, 'h44,   1, 0);
        vecs[15] = mk(0, 0, 0, 0,     1, 16, 'h10,  1, 1, 15, 'hF,   1, 0);
        vecs[16] = mk(0, 0, 0, 0,     0, 0, 0,      1, 1, 16, 'h10,  0, 0);
        vecs[17] = mk(0, 0, 0, 0,     0, 0, 0,      1, 0, 16, 'h10,  0, 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            RESET = vecs[i].rst; PIPE_WRITE = vecs[i].pw; PIPE_ADDR = vecs[i].pa;
            PIPE_DATA = vecs[i].pd; MDU_VALID = vecs[i].mv; MDU_ADDR = vecs[i].ma;
            MDU_DATA = vecs[i].md;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(MDU_READY), 32'(vecs[i].e_rdy));
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_write", i), 32'(RF_WRITE), 32'(vecs[i].e_w));
            chk($sformatf("vec%0d_addr", i), 32'(RF_ADDR), 32'(vecs[i].e_a));
            chk($sformatf("vec%0d_data", i), RF_DATA, vecs[i].e_d);
            chk($sformatf("vec%0d_pending", i), 32'(PENDING), 32'(vecs[i].e_p));
            chk($sformatf("vec%0d_stall", i), 32'(STALL_REQ), 32'(vecs[i].e_s));
        end

        // Starvation: FIFO full behind continuous pipeline writes, then drained.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h100, 1, 20, 32'h1);
        chk("starve_w0_addr", 32'(RF_ADDR), 32'd1);
        chk("starve_w0_pending", 32'(PENDING), 32'd1);
        cyc(0, 1, 2, 32'h101, 1, 21, 32'h2);
        chk("starve_w1_pending", 32'(PENDING), 32'd2);
        chk("starve_full_ready", 32'(MDU_READY), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 3, 32'(200 + i), 1, 22, 32'h3);
            chk($sformatf("starve%0d_write", i), 32'(RF_WRITE), 32'd1);
            chk($sformatf("starve%0d_data", i), RF_DATA, 32'(200 + i));
            chk($sformatf("starve%0d_pending", i), 32'(PENDING), 32'd2);
            chk($sformatf("starve%0d_ready", i), 32'(MDU_READY), 32'd0);
            chk($sformatf("starve%0d_stall", i), 32'(STALL_REQ), (i >= 8) ? 32'd1 : 32'd0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("drain0_addr", 32'(RF_ADDR), 32'd20);
        chk("drain0_data", RF_DATA, 32'h1);
        chk("drain0_pending", 32'(PENDING), 32'd1);
        chk("drain0_stall", 32'(STALL_REQ), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("drain1_addr", 32'(RF_ADDR), 32'd21);
        chk("drain1_data", RF_DATA, 32'h2);
        chk("drain1_pending", 32'(PENDING), 32'd0);
        chk("drain1_stall", 32'(STALL_REQ), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("drain2_write", 32'(RF_WRITE), 32'd0);
        chk("drain2_stall", 32'(STALL_REQ), 32'd0);

        // Random traffic against a queue model of the arbiter.
        cyc(1, 0, 0, 0, 0, 0, 0);
        last_a = '0;
        last_d = '0;
        for (int n = 0; n < 400; n++) begin
            pw = ($urandom_range(0, 99) < 45);
            mv = ($urandom_range(0, 99) < 55);
            pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pd = $urandom;
            md = $urandom;
            @(negedge CLK);
            RESET = 1'b0; PIPE_WRITE = pw; PIPE_ADDR = pa; PIPE_DATA = pd;
            MDU_VALID = mv; MDU_ADDR = ma; MDU_DATA = md;
            erdy = (mfifo.size() < 2);
            preq = pw && (pa != 5'd0);
            take = mv && erdy && (ma != 5'd0);
            if (preq) begin
                e = '{w: 1'b1, a: pa, d: pd};
                if (take) mfifo.push_back({ma, md});
            end else if (mfifo.size() > 0) begin
                ent = mfifo.pop_front();
                e = '{w: 1'b1, a: ent[36:32], d: ent[31:0]};
                if (take) mfifo.push_back({ma, md});
            end else if (take) begin
                e = '{w: 1'b1, a: ma, d: md};
            end else begin
                e = '{w: 1'b0, a: last_a, d: last_d};
            end
            last_a = e.a;
            last_d = e.d;
            sb.push_back(e);
            #1;
            chk("rnd_ready", 32'(MDU_READY), 32'(erdy));
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            chk("rnd_write", 32'(RF_WRITE), 32'(e.w));
            chk("rnd_addr", 32'(RF_ADDR), 32'(e.a));
            chk("rnd_data", RF_DATA, e.d);
            chk("rnd_pending", 32'(PENDING), 32'(mfifo.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
